// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequenced ALU decoder: opcodes, FSM states,
// carry-mode encoding and the per-opcode operand-field table.
package alu_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_SHIFT = 2'd2,
    S_MUL   = 2'd3
  } state_e;

  // Carry-mode field INSTR[9:8]
  typedef enum logic [1:0] {
    CM_ZERO  = 2'd0,
    CM_ONE   = 2'd1,
    CM_CARRY = 2'd2,
    CM_MSB   = 2'd3
  } carry_mode_e;

  // Decoded operation class; OP_ILL covers every unlisted opcode
  typedef enum logic [3:0] {
    OP_ILL = 4'd0,
    OP_ADR = 4'd1,
    OP_ADM = 4'd2,
    OP_ADI = 4'd3,
    OP_SBR = 4'd4,
    OP_SBM = 4'd5,
    OP_SBI = 4'd6,
    OP_MLR = 4'd7,
    OP_XSL = 4'd8,
    OP_XSR = 4'd9,
    OP_BBO = 4'd10,
    OP_STK = 4'd11,
    OP_LDR = 4'd12,
    OP_STI = 4'd13,
    OP_JMR = 4'd14
  } op_e;

  // Opcode values of INSTR[15:11]; adm and sbm each own two codes
  localparam logic [4:0] OPC_ADR   = 5'b00001;
  localparam logic [4:0] OPC_ADM_A = 5'b00010;
  localparam logic [4:0] OPC_ADM_B = 5'b00011;
  localparam logic [4:0] OPC_ADI   = 5'b00100;
  localparam logic [4:0] OPC_SBR   = 5'b00101;
  localparam logic [4:0] OPC_SBM_A = 5'b00110;
  localparam logic [4:0] OPC_SBM_B = 5'b00111;
  localparam logic [4:0] OPC_SBI   = 5'b01000;
  localparam logic [4:0] OPC_MLR   = 5'b01001;
  localparam logic [4:0] OPC_XSL   = 5'b01010;
  localparam logic [4:0] OPC_XSR   = 5'b01011;
  localparam logic [4:0] OPC_BBO   = 5'b01100;
  localparam logic [4:0] OPC_STK   = 5'b01101;
  localparam logic [4:0] OPC_LDR   = 5'b01110;
  localparam logic [4:0] OPC_STI   = 5'b01111;
  localparam logic [4:0] OPC_JMR   = 5'b11100;

  // Datapath selects produced for one operation
  typedef struct packed {
    logic [2:0] rn;
    logic [2:0] rm;
    logic [1:0] rx;
    logic [1:0] op;
    logic [2:0] cout;
    logic       add_sub;
  } fields_t;

  function automatic op_e decode_op(input logic [4:0] opc);
    op_e r;
    case (opc)
      OPC_ADR:              r = OP_ADR;
      OPC_ADM_A, OPC_ADM_B: r = OP_ADM;
      OPC_ADI:              r = OP_ADI;
      OPC_SBR:              r = OP_SBR;
      OPC_SBM_A, OPC_SBM_B: r = OP_SBM;
      OPC_SBI:              r = OP_SBI;
      OPC_MLR:              r = OP_MLR;
      OPC_XSL:              r = OP_XSL;
      OPC_XSR:              r = OP_XSR;
      OPC_BBO:              r = OP_BBO;
      OPC_STK:              r = OP_STK;
      OPC_LDR:              r = OP_LDR;
      OPC_STI:              r = OP_STI;
      OPC_JMR:              r = OP_JMR;
      default:              r = OP_ILL;
    endcase
    return r;
  endfunction

  // Operand-field table. rm: 1=register, 2=memory, 3=immediate, 4=stack.
  // op: 0=adder, 1=multiplier, 2=shifter, 3=logic. add_sub=1 means add.
  function automatic fields_t field_table(input op_e op);
    fields_t f;
    //            rn    rm    rx    op    cout  add
    case (op)
      OP_ADR:  f = {3'd1, 3'd1, 2'd0, 2'd0, 3'd1, 1'b1};
      OP_ADM:  f = {3'd1, 3'd2, 2'd0, 2'd0, 3'd1, 1'b1};
      OP_ADI:  f = {3'd1, 3'd3, 2'd0, 2'd0, 3'd1, 1'b1};
      OP_SBR:  f = {3'd1, 3'd1, 2'd0, 2'd0, 3'd2, 1'b0};
      OP_SBM:  f = {3'd1, 3'd2, 2'd0, 2'd0, 3'd2, 1'b0};
      OP_SBI:  f = {3'd1, 3'd3, 2'd0, 2'd0, 3'd2, 1'b0};
      OP_MLR:  f = {3'd1, 3'd1, 2'd1, 2'd1, 3'd3, 1'b1};
      OP_XSL:  f = {3'd1, 3'd0, 2'd2, 2'd2, 3'd4, 1'b0};
      OP_XSR:  f = {3'd1, 3'd0, 2'd2, 2'd2, 3'd5, 1'b0};
      OP_BBO:  f = {3'd2, 3'd1, 2'd0, 2'd3, 3'd0, 1'b0};
      OP_STK:  f = {3'd3, 3'd4, 2'd3, 2'd0, 3'd0, 1'b1};
      OP_LDR:  f = {3'd4, 3'd1, 2'd0, 2'd0, 3'd0, 1'b1};
      OP_STI:  f = {3'd5, 3'd3, 2'd0, 2'd0, 3'd0, 1'b1};
      OP_JMR:  f = {3'd6, 3'd1, 2'd0, 2'd0, 3'd0, 1'b1};
      default: f = '0;
    endcase
    return f;
  endfunction

  // Picks 0, 1, carry or Rm MSB according to the carry mode
  function automatic logic carry_select(input carry_mode_e cm, input logic c, input logic m);
    logic r;
    case (cm)
      CM_ZERO:  r = 1'b0;
      CM_ONE:   r = 1'b1;
      CM_CARRY: r = c;
      CM_MSB:   r = m;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_step_counter.sv
// Loadable down-counter used to pace shift and multiply iterations.
// It is loaded with (steps-1) so the zero flag marks the final step.
module alu_step_counter
  import alu_seq_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load on acceptance, otherwise count down to zero and stick there
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/alu_seq_decoder.sv
// Multi-cycle ALU instruction sequencer: accepts one instruction at a time,
// then emits one issue cycle or a run of shift/multiply step cycles.
module alu_seq_decoder
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic        CARRY,
  input  logic        RM_MSB,
  output logic [2:0]  RN_SEL,
  output logic [2:0]  RM_SEL,
  output logic [1:0]  RX_SEL,
  output logic [1:0]  OP_SEL,
  output logic [2:0]  COUT_SEL,
  output logic        ADD_SUB,
  output logic        CIN,
  output logic        MULT,
  output logic        BBO,
  output logic        SHIFT_RIGHT,
  output logic        SHIFT_IN,
  output logic        SHIFT_STEP,
  output logic        MUL_STEP,
  output logic        OP_VALID,
  output logic        OP_LAST,
  output logic        ILLEGAL
);

  state_e       r_state;
  state_e       w_next;
  op_e          r_op;
  carry_mode_e  r_cm;
  logic         r_carry;
  logic         r_rmmsb;

  op_e          w_in_op;
  logic [SHAMT_W-1:0] w_in_raw;
  logic [SHAMT_W-1:0] w_in_amt;
  logic [SHAMT_W-1:0] w_load_val;
  logic         w_accept;
  logic         w_cnt_zero;
  logic         w_cm_bit;
  fields_t      w_fields;
  logic         w_unused_bits;

  assign w_in_op  = decode_op(INSTR[15:11]);
  assign w_in_raw = SHAMT_W'(INSTR[7:4]);
  assign w_in_amt = (w_in_raw > SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : w_in_raw;
  assign w_accept = INSTR_VALID && (r_state == S_IDLE);
  assign w_load_val = (w_in_op == OP_MLR) ? SHAMT_W'(WIDTH - 1) : (w_in_amt - SHAMT_W'(1));
  assign w_fields = field_table(r_op);
  assign w_cm_bit = carry_select(r_cm, r_carry, r_rmmsb);
  assign w_unused_bits = ^{INSTR[10], INSTR[3:0]};

  alu_step_counter #(.W(SHAMT_W)) u_step_counter (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      ((r_state == S_SHIFT) || (r_state == S_MUL)),
    .o_zero     (w_cnt_zero)
  );

  // State register plus the decoded instruction captured at acceptance
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_op    <= OP_ILL;
      r_cm    <= CM_ZERO;
      r_carry <= 1'b0;
      r_rmmsb <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= w_in_op;
        r_cm    <= carry_mode_e'(INSTR[9:8]);
        r_carry <= CARRY;
        r_rmmsb <= RM_MSB;
      end
    end
  end

  // Next-state sequencing and control outputs, all zero outside OP_VALID
  always_comb begin
    w_next      = r_state;
    INSTR_READY = 1'b0;
    RN_SEL      = '0;
    RM_SEL      = '0;
    RX_SEL      = '0;
    OP_SEL      = '0;
    COUT_SEL    = '0;
    ADD_SUB     = 1'b0;
    CIN         = 1'b0;
    MULT        = 1'b0;
    BBO         = 1'b0;
    SHIFT_RIGHT = 1'b0;
    SHIFT_IN    = 1'b0;
    SHIFT_STEP  = 1'b0;
    MUL_STEP    = 1'b0;
    OP_VALID    = 1'b0;
    OP_LAST     = 1'b0;
    ILLEGAL     = 1'b0;

    case (r_state)
      S_IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) begin
          if (w_in_op == OP_MLR) begin
            w_next = S_MUL;
          end else if (((w_in_op == OP_XSL) || (w_in_op == OP_XSR)) && (w_in_amt != '0)) begin
            w_next = S_SHIFT;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: w_next = S_IDLE;
      S_SHIFT, S_MUL: begin
        if (w_cnt_zero) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase

    if (r_state != S_IDLE) begin
      OP_VALID = 1'b1;
      OP_LAST  = (r_state == S_ISSUE) || w_cnt_zero;
      if (r_op == OP_ILL) begin
        ILLEGAL = 1'b1;
      end else begin
        RN_SEL     = w_fields.rn;
        RM_SEL     = w_fields.rm;
        RX_SEL     = w_fields.rx;
        OP_SEL     = w_fields.op;
        COUT_SEL   = w_fields.cout;
        ADD_SUB    = w_fields.add_sub;
        BBO        = (r_op == OP_BBO);
        MULT       = (r_op == OP_MLR);
        MUL_STEP   = (r_state == S_MUL);
        SHIFT_STEP = (r_state == S_SHIFT);
        case (r_op)
          OP_ADR, OP_ADM, OP_ADI: CIN = w_cm_bit;
          OP_SBR:                 CIN = ~w_cm_bit;
          OP_SBM, OP_SBI:         CIN = 1'b1;
          default:                CIN = 1'b0;
        endcase
        if ((r_op == OP_XSL) || (r_op == OP_XSR)) begin
          SHIFT_IN    = w_cm_bit;
          SHIFT_RIGHT = (r_op == OP_XSR);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_decoder.sv
// Directed bench for alu_seq_decoder: a WIDTH=16 instance for most
// instructions and a WIDTH=8 instance for shift-amount saturation.
module tb_alu_seq_decoder;

  // Control bit layout of ctrlA/ctrlB
  localparam logic [10:0] B_ADD  = 11'h400;
  localparam logic [10:0] B_CIN  = 11'h200;
  localparam logic [10:0] B_MULT = 11'h100;
  localparam logic [10:0] B_BBO  = 11'h080;
  localparam logic [10:0] B_SR   = 11'h040;
  localparam logic [10:0] B_SI   = 11'h020;
  localparam logic [10:0] B_SS   = 11'h010;
  localparam logic [10:0] B_MS   = 11'h008;
  localparam logic [10:0] B_VAL  = 11'h004;
  localparam logic [10:0] B_LAST = 11'h002;
  localparam logic [10:0] B_ILL  = 11'h001;

  // Select layout {rn, rm, rx, op, cout}
  localparam logic [12:0] SEL_ADR = 13'b001_001_00_00_001;
  localparam logic [12:0] SEL_ADI = 13'b001_011_00_00_001;
  localparam logic [12:0] SEL_SBR = 13'b001_001_00_00_010;
  localparam logic [12:0] SEL_MLR = 13'b001_001_01_01_011;
  localparam logic [12:0] SEL_XSL = 13'b001_000_10_10_100;
  localparam logic [12:0] SEL_XSR = 13'b001_000_10_10_101;
  localparam logic [12:0] SEL_BBO = 13'b010_001_00_11_000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] instr;
  logic        validA, validB, carry, rmMsb;
  wire         readyA, readyB;
  wire  [10:0] ctrlA, ctrlB;
  wire  [12:0] selA, selB;
  int          nCompared = 0;
  int          nMismatch = 0;
  logic        sawLast;

  always #5 CLK = ~CLK;

  alu_seq_decoder #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .INSTR(instr), .INSTR_VALID(validA), .INSTR_READY(readyA),
    .CARRY(carry), .RM_MSB(rmMsb),
    .RN_SEL(selA[12:10]), .RM_SEL(selA[9:7]), .RX_SEL(selA[6:5]), .OP_SEL(selA[4:3]), .COUT_SEL(selA[2:0]),
    .ADD_SUB(ctrlA[10]), .CIN(ctrlA[9]), .MULT(ctrlA[8]), .BBO(ctrlA[7]), .SHIFT_RIGHT(ctrlA[6]),
    .SHIFT_IN(ctrlA[5]), .SHIFT_STEP(ctrlA[4]), .MUL_STEP(ctrlA[3]), .OP_VALID(ctrlA[2]),
    .OP_LAST(ctrlA[1]), .ILLEGAL(ctrlA[0])
  );

  alu_seq_decoder #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RESET(RESET), .INSTR(instr), .INSTR_VALID(validB), .INSTR_READY(readyB),
    .CARRY(carry), .RM_MSB(rmMsb),
    .RN_SEL(selB[12:10]), .RM_SEL(selB[9:7]), .RX_SEL(selB[6:5]), .OP_SEL(selB[4:3]), .COUT_SEL(selB[2:0]),
    .ADD_SUB(ctrlB[10]), .CIN(ctrlB[9]), .MULT(ctrlB[8]), .BBO(ctrlB[7]), .SHIFT_RIGHT(ctrlB[6]),
    .SHIFT_IN(ctrlB[5]), .SHIFT_STEP(ctrlB[4]), .MUL_STEP(ctrlB[3]), .OP_VALID(ctrlB[2]),
    .OP_LAST(ctrlB[1]), .ILLEGAL(ctrlB[0])
  );

  task automatic applyStimulus(input logic [15:0] i, input logic vA, input logic vB,
                               input logic c, input logic m);
    instr  = i;
    validA = vA;
    validB = vB;
    carry  = c;
    rmMsb  = m;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Single-cycle instruction on dut16: accept, check issue cycle, check idle
  task automatic singleIssue(input string tag, input logic [15:0] i, input logic c,
                             input logic [10:0] expCtrl, input logic [12:0] expSel);
    applyStimulus(i, 1'b1, 1'b0, c, 1'b0);
    @(negedge CLK);
    applyStimulus(16'h0000, 1'b0, 1'b0, ~c, 1'b1);
    #1;
    checkOutput({tag, "_ctrl"}, 32'(ctrlA), 32'(expCtrl));
    checkOutput({tag, "_sel"}, 32'(selA), 32'(expSel));
    checkOutput({tag, "_ready_busy"}, 32'(readyA), 32'd0);
    @(negedge CLK);
    #1;
    checkOutput({tag, "_ready_after"}, 32'(readyA), 32'd1);
    checkOutput({tag, "_idle_ctrl"}, 32'(ctrlA), 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("reset_ready16", 32'(readyA), 32'd1);
    checkOutput("reset_ctrl16", 32'(ctrlA), 32'd0);
    checkOutput("reset_sel16", 32'(selA), 32'd0);
    checkOutput("reset_ready8", 32'(readyB), 32'd1);
    checkOutput("reset_ctrl8", 32'(ctrlB), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // adr, CM=00: CIN=0, add
    singleIssue("adr", 16'h0800, 1'b0, B_ADD | B_VAL | B_LAST, SEL_ADR);

    // xsl N=3 CM=01: three shift steps, SHIFT_IN=1, last on third
    applyStimulus(16'h5130, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i == 0) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("xsl3_ctrl_%0d", i), 32'(ctrlA),
                  32'(B_SI | B_SS | B_VAL | ((i == 2) ? B_LAST : 11'h000)));
      checkOutput($sformatf("xsl3_sel_%0d", i), 32'(selA), 32'(SEL_XSL));
    end
    @(negedge CLK);
    #1;
    checkOutput("xsl3_idle_ctrl", 32'(ctrlA), 32'd0);
    checkOutput("xsl3_ready", 32'(readyA), 32'd1);

    // mlr: 16 multiply steps, then adi (CM=10, CARRY=1) waiting behind it
    applyStimulus(16'h4800, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (i == 0) applyStimulus(16'h2200, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("mlr_ctrl_%0d", i), 32'(ctrlA),
                  32'(B_ADD | B_MULT | B_MS | B_VAL | ((i == 15) ? B_LAST : 11'h000)));
      checkOutput($sformatf("mlr_sel_%0d", i), 32'(selA), 32'(SEL_MLR));
      checkOutput($sformatf("mlr_ready_%0d", i), 32'(readyA), 32'd0);
    end
    @(negedge CLK);
    #1;
    checkOutput("mlr_ready_after_last", 32'(readyA), 32'd1);
    checkOutput("mlr_idle_ctrl", 32'(ctrlA), 32'd0);
    @(negedge CLK);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("adi_b2b_ctrl", 32'(ctrlA), 32'(B_ADD | B_CIN | B_VAL | B_LAST));
    checkOutput("adi_b2b_sel", 32'(selA), 32'(SEL_ADI));
    @(negedge CLK);

    // sbr CM=10 with CARRY=0 sampled: CIN = ~CARRY = 1, subtract
    singleIssue("sbr", 16'h2A00, 1'b0, B_CIN | B_VAL | B_LAST, SEL_SBR);

    // bbo
    singleIssue("bbo", 16'h6000, 1'b0, B_BBO | B_VAL | B_LAST, SEL_BBO);

    // xsl N=0 CM=01: pass-through, no SHIFT_STEP
    singleIssue("xsl0", 16'h5100, 1'b0, B_SI | B_VAL | B_LAST, SEL_XSL);

    // xsl N=1 CM=00: a single step that is also the last
    singleIssue("xsl1", 16'h5010, 1'b0, B_SS | B_VAL | B_LAST, SEL_XSL);

    // illegal opcode 10000
    singleIssue("illegal", 16'h8000, 1'b0, B_ILL | B_VAL | B_LAST, 13'd0);

    // WIDTH=8 xsr N=15 CM=10, CARRY=1: saturates to 8 steps, SHIFT_IN=1
    applyStimulus(16'h5AF0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("xsr8_ctrl_%0d", i), 32'(ctrlB),
                  32'(B_SR | B_SI | B_SS | B_VAL | ((i == 7) ? B_LAST : 11'h000)));
      checkOutput($sformatf("xsr8_sel_%0d", i), 32'(selB), 32'(SEL_XSR));
    end
    @(negedge CLK);
    #1;
    checkOutput("xsr8_idle_ctrl", 32'(ctrlB), 32'd0);
    checkOutput("xsr8_ready", 32'(readyB), 32'd1);

    // Reset asserted during the 5th multiply step
    applyStimulus(16'h4800, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i == 0) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    #1;
    checkOutput("rst_mid_step5_ctrl", 32'(ctrlA), 32'(B_ADD | B_MULT | B_MS | B_VAL));
    RESET = 1'b1;
    #1;
    checkOutput("rst_mid_ready", 32'(readyA), 32'd1);
    checkOutput("rst_mid_ctrl", 32'(ctrlA), 32'd0);
    checkOutput("rst_mid_sel", 32'(selA), 32'd0);
    sawLast = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #1;
      if (ctrlA[1] || ctrlA[2]) sawLast = 1'b1;
    end
    checkOutput("rst_mid_no_last", 32'(sawLast), 32'd0);
    checkOutput("rst_mid_ready_after", 32'(readyA), 32'd1);

    // Fresh instruction after the abandoned multiply
    @(negedge CLK);
    singleIssue("adr_after_rst", 16'h0800, 1'b0, B_ADD | B_VAL | B_LAST, SEL_ADR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/alu_seq_decoder.md
ALU_SEQ_DECODER -- requirements
Module: alu_seq_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath width, legal values 8/16/32.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH)+1: shift-amount field width.
REQ-003 SHALL have port CLK, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports INSTR input 16, INSTR_VALID input 1, INSTR_READY output 1: instruction handshake.
REQ-006 SHALL have ports CARRY input 1 and RM_MSB input 1 (Rm[WIDTH-1]): carry sources, sampled at acceptance.
REQ-007 SHALL have outputs RN_SEL 3, RM_SEL 3, RX_SEL 2, OP_SEL 2, COUT_SEL 3: registered datapath selects.
REQ-008 SHALL have outputs ADD_SUB, CIN, MULT, BBO, SHIFT_RIGHT, SHIFT_IN, SHIFT_STEP, MUL_STEP, each 1 bit: registered controls.
REQ-009 SHALL have outputs OP_VALID, OP_LAST, ILLEGAL, each 1 bit: step qualifier, final-step flag, bad-opcode flag.

Function
REQ-010 SHALL decode opcode INSTR[15:11]: adr 00001, adm 0001x, adi 00100, sbr 00101, sbm 0011x, sbi 01000, mlr 01001, xsl 01010, xsr 01011, bbo 01100, stk 01101, ldr 01110, sti 01111, jmr 11100; all others illegal.
REQ-011 SHALL derive RN_SEL/RM_SEL/RX_SEL, OP_SEL, COUT_SEL, ADD_SUB from the package operand-field table, identical per opcode to the current single-cycle ISA.
REQ-012 SHALL derive carry mode CM = INSTR[9:8]: add CIN = {0,1,CARRY,RM_MSB}; sbr CIN = {1,0,~CARRY,~RM_MSB}; sbm/sbi CIN=1; shifts SHIFT_IN = {0,1,CARRY,RM_MSB}.
REQ-013 SHALL implement FSM states IDLE, ISSUE, SHIFT, MUL; INSTR_READY=1 only in IDLE.
REQ-014 SHALL accept an instruction when INSTR_VALID & INSTR_READY, registering INSTR, CARRY, RM_MSB on that edge.
REQ-015 SHALL, for single-cycle and illegal opcodes, go IDLE->ISSUE->IDLE: one OP_VALID=OP_LAST=1 cycle, one cycle after acceptance.
REQ-016 SHALL assert ILLEGAL with OP_VALID in the ISSUE cycle for illegal opcodes, all other controls 0.
REQ-017 SHALL, for xsl/xsr, take amount N = INSTR[7:4] zero-extended to SHAMT_W, saturated to WIDTH.
REQ-018 SHALL, for shifts, emit N consecutive OP_VALID&SHIFT_STEP cycles with OP_LAST on the Nth; SHIFT_RIGHT=1 for xsr only.
REQ-019 SHALL treat N=0 as one OP_VALID&OP_LAST cycle with SHIFT_STEP=0 (pass-through).
REQ-020 SHALL, for mlr, emit exactly WIDTH consecutive OP_VALID&MUL_STEP cycles, MULT=1 throughout, OP_LAST on the final one.
REQ-021 SHALL hold all select outputs constant for an entire multi-cycle operation.
REQ-022 SHALL accept the next instruction in the cycle after OP_LAST, giving back-to-back throughput of (steps+1) cycles per instruction.
REQ-023 SHALL drive all control outputs to 0 whenever OP_VALID=0.

Reset
REQ-024 SHALL, on RESET assertion (including mid-operation), go to IDLE immediately and clear all outputs to 0, INSTR_READY excepted.
REQ-025 SHALL drive INSTR_READY=1 from reset and SHALL abandon any in-flight operation without emitting OP_LAST.

Structure
REQ-026 SHALL place opcode constants, state encoding, carry-mode encoding and the operand-field table function in shared package alu_seq_pkg.
REQ-027 SHALL use one sub-module, alu_step_counter (SHAMT_W-bit loadable down-counter with zero flag), for shift and multiply iteration.

Verification
REQ-028 SHALL verify INSTR=0x0800 (adr, CM=00) accepted -> next cycle one OP_VALID=OP_LAST=1, ADD_SUB=1, CIN=0, INSTR_READY=0 for that cycle only.
REQ-029 SHALL verify INSTR=0x5130 (xsl, N=3, CM=01) -> SHIFT_STEP for exactly 3 cycles, SHIFT_IN=1, SHIFT_RIGHT=0, OP_LAST on the 3rd.
REQ-030 SHALL verify INSTR=0x4800 (mlr), WIDTH=16 -> 16 MUL_STEP cycles, OP_LAST on the 16th, next accepted 17 cycles after the first.
REQ-031 SHALL verify INSTR=0x5AF0 (xsr, N=15, CM=10), WIDTH=8 -> saturates to 8 SHIFT_STEP cycles, SHIFT_IN=CARRY as sampled.
REQ-032 SHALL verify INSTR=0x8000 -> one cycle ILLEGAL=OP_VALID=OP_LAST=1, all others 0.
REQ-033 SHALL verify RESET asserted at the 5th MUL_STEP -> outputs 0 and INSTR_READY=1 without waiting for a clock edge, and no OP_LAST.
